// File: rtl/add_sub_pkg.sv
// Shared encodings for the digit-serial add/subtract unit: operation codes,
// FSM state type and the carry-in selection rule.
package add_sub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // SUB starts with carry 1 to complete the two's-complement negation of b.
    function automatic logic initial_carry(input logic [1:0] op, input logic cflag);
        logic c;
        c = cflag;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cflag;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/add_sub_serial_digit_adder.sv
// Combinational DIGIT-bit adder slice used once per cycle by the serial datapath.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial add/subtract with carry chaining across operations (ADC/SBB).
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module add_sub_serial
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output state_t           dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CW-1:0]      r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_cflag;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;
    logic               r_negative;

    logic [DIGIT-1:0]       w_dsum;
    logic                   w_dcout;
    logic [WIDTH+DIGIT-1:0] w_shift;
    logic [WIDTH-1:0]       w_sum_next;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .cin  (r_carry),
        .sum  (w_dsum),
        .cout (w_dcout)
    );

    // New digit enters at the MSB end; after N shifts the first digit sits at bit 0.
    assign w_shift    = {w_dsum, r_sum};
    assign w_sum_next = w_shift[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_cflag     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{op[0]}};
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1] ^ op[0];
                        r_carry <= initial_carry(op, r_cflag);
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dcout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state     <= ST_DONE;
                        r_result    <= w_sum_next;
                        r_carry_out <= w_dcout;
                        r_overflow  <= (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
                        r_zero      <= (w_sum_next == '0);
                        r_negative  <= w_sum_next[WIDTH-1];
                        r_cflag     <= w_dcout;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign dbg_state = r_state;

endmodule

// File: doc/add_sub_serial.md
ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op presented
- in_ready  out  1  block accepts operands
- a  in  WIDTH  first operand
- b  in  WIDTH  second operand
- op  in  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- carry_out  out  1  carry; 1 = no borrow for SUB/SBB
- overflow  out  1  signed two's-complement overflow
- zero  out  1  result == 0
- negative  out  1  result MSB

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE.
REQ-007 out_valid SHALL be 1 only in DONE.
REQ-008 On acceptance (in_valid && in_ready at a rising edge), the block SHALL latch the operands and enter RUN:
- latches a and b_eff = b XOR {WIDTH{op[0]}}
- initial carry: ADD 0, SUB 1, ADC/SBB = stored carry flag (cflag)
REQ-009 In RUN, each cycle SHALL add the low DIGIT bits of a and b_eff plus the running carry, shift the sum in from the result MSB end, shift both operands right by DIGIT, and register the digit carry.
REQ-010 After exactly N RUN cycles, the block SHALL enter DONE, so out_valid rises on the Nth rising edge after the acceptance edge.
REQ-011 On entering DONE, the block SHALL update the outputs and cflag:
- carry_out = final carry
- overflow = (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]), using the original latched MSBs
- zero and negative derived from result
- cflag <= carry_out
REQ-012 In DONE, result and all flags SHALL be held stable until out_ready = 1 at a rising edge, after which the state SHALL return to IDLE.
REQ-013 result and flags SHALL keep their last values in IDLE and RUN; only out_valid qualifies them.
REQ-014 in_valid, a, b and op SHALL be ignored outside IDLE; no queuing.
REQ-015 Back-to-back throughput SHALL be one operation per N+2 cycles with out_ready and in_valid held high.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH; carry_out is bit WIDTH of the unsigned sum.
REQ-017 An out_ready pulse outside DONE SHALL have no effect.

Reset
REQ-018 rst_n low SHALL, asynchronously and in any state including mid-RUN, force:
- state IDLE
- result, carry_out, overflow, zero, negative, cflag, the operand registers and the digit carry all to 0
- in_ready = 1 and out_valid = 0 once the state is IDLE
REQ-019 An operation interrupted by reset SHALL be discarded, with no partial result output.

Structure
REQ-020 Package add_sub_pkg SHALL hold the op encoding constants (OP_ADD, OP_SUB, OP_ADC, OP_SBB) and the FSM state encoding.
REQ-021 A combinational sub-module digit_adder (DIGIT-bit a, b, cin -> DIGIT-bit sum, cout) SHALL be instantiated once.
REQ-022 The FSM, the digit counter (ceil(log2 N) bits, minimum 1) and the shift registers SHALL live in add_sub_serial.

Verification (WIDTH=16, DIGIT=4)
REQ-023 ADD a=0x1234, b=0x0FFF -> out_valid 4 cycles after accept; result 0x2233, carry_out 0, overflow 0, zero 0, negative 0.
REQ-024 SUB a=0x0005, b=0x0007 -> result 0xFFFE, carry_out 0 (borrow), negative 1, overflow 0.
REQ-025 ADD 0xFFFF+0x0001 -> result 0x0000, carry_out 1, zero 1; then ADC 0x0001+0x0000 -> 0x0002, carry_out 0; then SBB 0x0005-0x0001 with cflag 0 -> 0x0003.
REQ-026 ADD 0x7FFF+0x0001 -> 0x8000, overflow 1, negative 1; SUB 0x8000-0x0001 -> 0x7FFF, overflow 1, carry_out 1.
REQ-027 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> result and flags unchanged, in_ready 0, the new operands are not accepted; out_ready=1 -> IDLE next cycle.
REQ-028 Assert rst_n=0 two cycles into RUN -> all outputs 0 immediately; after release in_ready=1, cflag 0 (verified via ADC 0x0000+0x0000 -> 0x0000, zero 1).
